// File: rtl/opb_register_simulink2ppc_latched.sv
// opb_register_simulink2ppc_latched
//
// Read-back OPB slave register for fabric-to-processor data. Fabric logic
// presents a 32-bit word with a capture strobe, and the block latches that
// word. The PowerPC reads the captured word over OPB, together with the
// freshness, overrun and update-count status.
//
// Register map (byte offsets from C_BASEADDR, word picked by OPB_ABus[28:29]):
//   0x0 DATA     RO   last captured word
//   0x4 STATUS        [31] fresh (W1C), [30] overrun (W1C), [15:0] update count
//                     W1C bits are gated by OPB_BE[0]
//   0x8 CONTROL       [0] freeze (RW), gated by OPB_BE[3]
//   0xC               reads 0, writes ignored, still acked
//
// Ports:
//   OPB_Clk           single clock for the bus side and the fabric side
//   OPB_Rst_n         synchronous, active-low reset
//   OPB_ABus          byte address, bit 0 is the MSB
//   OPB_BE            byte enables, BE[0] covers DBus[0:7]
//   OPB_DBus          write data
//   OPB_RNW           1 = read, 0 = write
//   OPB_select        transfer request
//   OPB_seqAddr       ignored
//   Sl_DBus           read data, zero outside the ack cycle
//   Sl_xferAck        one-cycle transfer acknowledge
//   Sl_errAck, Sl_retry, Sl_toutSup   tied low
//   user_data_in      fabric word to capture
//   user_data_valid   capture strobe, sampled every cycle
//   user_frozen       mirrors CONTROL.freeze
//
// Register bit k appears on bus bit 31-k. Because the bus vectors are
// declared [0:31] and the internal words are [31:0], a plain assignment
// performs that mapping.

module opb_register_simulink2ppc_latched #(
  parameter logic [31:0] C_BASEADDR   = 32'h01008300,
  parameter logic [31:0] C_HIGHADDR   = 32'h010083FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
  input  logic                        OPB_RNW,
  input  logic                        OPB_select,
  input  logic                        OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  input  logic [31:0]                 user_data_in,
  input  logic                        user_data_valid,
  output logic                        user_frozen
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // Word indices within the slave window.
  localparam logic [1:0] W_DATA    = 2'd0;
  localparam logic [1:0] W_STATUS  = 2'd1;
  localparam logic [1:0] W_CONTROL = 2'd2;

  state_t      state;
  logic [31:0] data_q;
  logic [15:0] count_q;
  logic        fresh_q;
  logic        overrun_q;
  logic        freeze_q;
  logic        xfer_ack_q;
  logic [31:0] dbus_q;

  logic        addr_hit;
  logic [1:0]  word_sel;
  logic [31:0] wr_data;
  logic        bus_go;
  logic        rd_go;
  logic        wr_go;
  logic        capture;
  logic [31:0] rd_word;
  logic        fresh_nxt;
  logic        overrun_nxt;
  logic        freeze_nxt;
  logic        unused_bits;

  // Address decode and transfer qualification. A transfer is only accepted
  // from IDLE, so a held select produces an ack every other cycle.
  always_comb begin
    addr_hit = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
    word_sel = OPB_ABus[28:29];
    wr_data  = OPB_DBus;
    bus_go   = (state == ST_IDLE) && OPB_select && addr_hit;
    rd_go    = bus_go && OPB_RNW;
    wr_go    = bus_go && !OPB_RNW;
    // freeze is the registered value, so a CONTROL write that sets freeze
    // on the same edge as a strobe still lets that strobe through.
    capture  = user_data_valid && !freeze_q;
  end

  // Read multiplexer: reflects register contents before the ack edge.
  always_comb begin
    rd_word = '0;
    unique case (word_sel)
      W_DATA:    rd_word = data_q;
      W_STATUS:  rd_word = {fresh_q, overrun_q, 14'd0, count_q};
      W_CONTROL: rd_word = {31'd0, freeze_q};
      default:   rd_word = '0;
    endcase
  end

  // Flag next-state. Bus-side clears are applied first and a capture then
  // overrides them, so a capture's set wins over a DATA-read clear or a W1C
  // on the same edge. Overrun looks at fresh as it was before this edge.
  always_comb begin
    fresh_nxt   = fresh_q;
    overrun_nxt = overrun_q;
    freeze_nxt  = freeze_q;

    if (rd_go && (word_sel == W_DATA)) begin
      fresh_nxt = 1'b0;
    end

    if (wr_go && (word_sel == W_STATUS) && OPB_BE[0]) begin
      if (wr_data[31]) fresh_nxt   = 1'b0;
      if (wr_data[30]) overrun_nxt = 1'b0;
    end

    if (wr_go && (word_sel == W_CONTROL) && OPB_BE[3]) begin
      freeze_nxt = wr_data[0];
    end

    if (capture) begin
      fresh_nxt = 1'b1;
      if (fresh_q) overrun_nxt = 1'b1;
    end
  end

  // Bus handshake FSM with registered outputs, plus the capture registers.
  always_ff @(posedge OPB_Clk) begin
    if (!OPB_Rst_n) begin
      state      <= ST_IDLE;
      xfer_ack_q <= 1'b0;
      dbus_q     <= '0;
      data_q     <= '0;
      count_q    <= '0;
      fresh_q    <= 1'b0;
      overrun_q  <= 1'b0;
      freeze_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus_go) begin
            state      <= ST_ACK;
            xfer_ack_q <= 1'b1;
            dbus_q     <= rd_go ? rd_word : '0;
          end else begin
            state      <= ST_IDLE;
            xfer_ack_q <= 1'b0;
            dbus_q     <= '0;
          end
        end
        ST_ACK: begin
          state      <= ST_IDLE;
          xfer_ack_q <= 1'b0;
          dbus_q     <= '0;
        end
        default: begin
          state      <= ST_IDLE;
          xfer_ack_q <= 1'b0;
          dbus_q     <= '0;
        end
      endcase

      fresh_q   <= fresh_nxt;
      overrun_q <= overrun_nxt;
      freeze_q  <= freeze_nxt;

      if (capture) begin
        data_q  <= user_data_in;
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign Sl_DBus     = dbus_q;
  assign Sl_xferAck  = xfer_ack_q;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = freeze_q;

  // Inputs with no function in this register.
  assign unused_bits = ^{OPB_seqAddr, OPB_BE[1:2], wr_data[29:1], (C_FAMILY != "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_latched.sv
module tb_opb_register_simulink2ppc_latched;

  localparam logic [31:0] BASE = 32'h01008300;

  logic        clk;
  logic        rst_n;
  logic [0:31] opb_abus;
  logic [0:3]  opb_be;
  logic [0:31] opb_dbus;
  logic        opb_rnw;
  logic        opb_select;
  logic        opb_seqaddr;
  logic [0:31] sl_dbus;
  logic        sl_xferack;
  logic        sl_errack;
  logic        sl_retry;
  logic        sl_toutsup;
  logic [31:0] user_data_in;
  logic        user_data_valid;
  logic        user_frozen;

  opb_register_simulink2ppc_latched #(
    .C_BASEADDR  (32'h01008300),
    .C_HIGHADDR  (32'h010083FF),
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_FAMILY    ("virtex6")
  ) dut (
    .OPB_Clk        (clk),
    .OPB_Rst_n      (rst_n),
    .OPB_ABus       (opb_abus),
    .OPB_BE         (opb_be),
    .OPB_DBus       (opb_dbus),
    .OPB_RNW        (opb_rnw),
    .OPB_select     (opb_select),
    .OPB_seqAddr    (opb_seqaddr),
    .Sl_DBus        (sl_dbus),
    .Sl_xferAck     (sl_xferack),
    .Sl_errAck      (sl_errack),
    .Sl_retry       (sl_retry),
    .Sl_toutSup     (sl_toutsup),
    .user_data_in   (user_data_in),
    .user_data_valid(user_data_valid),
    .user_frozen    (user_frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference model: register contents as plain variables.
  logic [31:0] m_data;
  int unsigned m_count;
  bit          m_fresh;
  bit          m_over;
  bit          m_freeze;

  function automatic void model_reset();
    m_data   = '0;
    m_count  = 0;
    m_fresh  = 0;
    m_over   = 0;
    m_freeze = 0;
  endfunction

  function automatic logic [31:0] model_read(input int unsigned w);
    logic [31:0] cnt;
    cnt = 32'(m_count);
    case (w)
      0:       return m_data;
      1:       return {m_fresh, m_over, 14'd0, cnt[15:0]};
      2:       return {31'd0, m_freeze};
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge worth of behaviour. b[3] is BE[0], b[0] is BE[3].
  function automatic void model_step(input bit acc, input bit rd, input int unsigned w,
                                     input logic [3:0] b, input logic [31:0] wd,
                                     input bit stb, input logic [31:0] sd);
    bit cap;
    bit old_fresh;
    cap       = stb && !m_freeze;
    old_fresh = m_fresh;
    if (acc) begin
      if (rd && w == 0) m_fresh = 0;
      if (!rd && w == 1 && b[3]) begin
        if (wd[31]) m_fresh = 0;
        if (wd[30]) m_over  = 0;
      end
      if (!rd && w == 2 && b[0]) m_freeze = wd[0];
    end
    if (cap) begin
      m_data  = sd;
      m_count = (m_count + 1) % 65536;
      if (old_fresh) m_over = 1;
      m_fresh = 1;
    end
  endfunction

  task automatic idle_inputs();
    opb_select      = 1'b0;
    opb_rnw         = 1'b0;
    opb_abus        = '0;
    opb_be          = '0;
    opb_dbus        = '0;
    opb_seqaddr     = 1'b0;
    user_data_valid = 1'b0;
    user_data_in    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One bus transfer launched in the current cycle, optionally with a
  // concurrent capture strobe. Checks ack, data, frozen and ack release.
  task automatic bus_op(input string name, input logic [31:0] addr, input bit rd,
                        input logic [3:0] b, input logic [31:0] wd,
                        input bit stb, input logic [31:0] sd,
                        input bit exp_hit, input logic [31:0] exp_rd);
    int unsigned w;
    w = int'(addr[3:2]);
    opb_abus        = addr;
    opb_rnw         = rd;
    opb_be          = b;
    opb_dbus        = rd ? 32'd0 : wd;
    opb_select      = 1'b1;
    user_data_valid = stb;
    user_data_in    = sd;
    @(posedge clk);
    #1;
    idle_inputs();
    model_step(exp_hit, rd, w, b, wd, stb, sd);
    check({name, " ack"}, {31'd0, sl_xferack}, {31'd0, exp_hit});
    check({name, " dbus"}, sl_dbus, (exp_hit && rd) ? exp_rd : 32'd0);
    check({name, " frozen"}, {31'd0, user_frozen}, {31'd0, m_freeze});
    @(posedge clk);
    #1;
    check({name, " ack release"}, {31'd0, sl_xferack}, 32'd0);
  endtask

  task automatic strobe(input logic [31:0] d);
    user_data_valid = 1'b1;
    user_data_in    = d;
    @(posedge clk);
    #1;
    user_data_valid = 1'b0;
    model_step(0, 0, 0, 4'h0, 32'd0, 1, d);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus_op(name, addr, 1'b1, 4'hF, 32'd0, 1'b0, 32'd0, 1'b1, exp);
  endtask

  task automatic wr_op(input string name, input logic [31:0] addr, input logic [3:0] b,
                       input logic [31:0] wd);
    bus_op(name, addr, 1'b0, b, wd, 1'b0, 32'd0, 1'b1, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int acks;
    bit back_to_back;
    bit prev_ack;
    bit bad_miss;

    rst_n = 1'b0;
    idle_inputs();
    model_reset();

    vecs[0]  = '{32'h01008304, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[1]  = '{32'h01008308, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[2]  = '{32'h01008308, 0, 4'b0001, 32'h1,     1, 32'h0};
    vecs[3]  = '{32'h01008308, 1, 4'hF, 32'h0,        1, 32'h00000001};
    vecs[4]  = '{32'h01008308, 0, 4'b1110, 32'h0,     1, 32'h0};
    vecs[5]  = '{32'h01008308, 1, 4'hF, 32'h0,        1, 32'h00000001};
    vecs[6]  = '{32'h01008308, 0, 4'b1111, 32'h0,     1, 32'h0};
    vecs[7]  = '{32'h01008308, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[8]  = '{32'h0100830C, 0, 4'hF, 32'hFFFFFFFF, 1, 32'h0};
    vecs[9]  = '{32'h0100830C, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[10] = '{32'h01008400, 1, 4'hF, 32'h0,        0, 32'h0};
    vecs[11] = '{32'h010083FF, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[12] = '{32'h010082FF, 1, 4'hF, 32'h0,        0, 32'h0};
    vecs[13] = '{32'h01008303, 1, 4'hF, 32'h0,        1, 32'h00000000};
    vecs[14] = '{32'h01008400, 0, 4'b0001, 32'h1,     0, 32'h0};

    // Reset state
    do_reset();
    check("reset ack", {31'd0, sl_xferack}, 32'd0);
    check("reset dbus", sl_dbus, 32'd0);
    check("reset frozen", {31'd0, user_frozen}, 32'd0);
    check("reset tie-offs", {29'd0, sl_errack, sl_retry, sl_toutsup}, 32'd0);

    // Table-driven bus accesses
    foreach (vecs[i]) begin
      bus_op($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rd, vecs[i].be, vecs[i].wd,
             1'b0, 32'd0, vecs[i].hit, vecs[i].exp);
    end

    // Single capture, fresh cleared by DATA read
    strobe(32'hDEADBEEF);
    rd_chk("status fresh", BASE + 32'h4, 32'h80000001);
    rd_chk("data capture", BASE, 32'hDEADBEEF);
    rd_chk("status after read", BASE + 32'h4, 32'h00000001);

    // Overrun then W1C
    do_reset();
    strobe(32'h11111111);
    strobe(32'h22222222);
    rd_chk("status overrun", BASE + 32'h4, 32'hC0000002);
    wr_op("w1c be0 off", BASE + 32'h4, 4'b0111, 32'hC0000000);
    rd_chk("status w1c gated", BASE + 32'h4, 32'hC0000002);
    wr_op("w1c", BASE + 32'h4, 4'b1000, 32'hC0000000);
    rd_chk("status after w1c", BASE + 32'h4, 32'h00000002);

    // Freeze behaviour
    do_reset();
    strobe(32'hA5A5A5A5);
    rd_chk("pre-freeze data", BASE, 32'hA5A5A5A5);
    wr_op("set freeze", BASE + 32'h8, 4'b0001, 32'h1);
    strobe(32'h12345678);
    rd_chk("frozen status", BASE + 32'h4, 32'h00000001);
    rd_chk("frozen data", BASE, 32'hA5A5A5A5);
    wr_op("clear freeze", BASE + 32'h8, 4'b0001, 32'h0);
    strobe(32'h12345678);
    rd_chk("resumed data", BASE, 32'h12345678);
    rd_chk("resumed status", BASE + 32'h4, 32'h00000002);
    bus_op("freeze with strobe", BASE + 32'h8, 1'b0, 4'b0001, 32'h1, 1'b1, 32'h00000055,
           1'b1, 32'd0);
    rd_chk("freeze-edge status", BASE + 32'h4, 32'h80000003);
    rd_chk("freeze-edge data", BASE, 32'h00000055);
    wr_op("unfreeze", BASE + 32'h8, 4'b0001, 32'h0);

    // Held select: ack every other cycle; then a miss never acks
    do_reset();
    acks = 0;
    back_to_back = 0;
    prev_ack = 0;
    opb_abus   = BASE;
    opb_rnw    = 1'b1;
    opb_be     = 4'hF;
    opb_select = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 6) opb_select = 1'b0;
      if (sl_xferack) begin
        acks++;
        if (prev_ack) back_to_back = 1;
      end
      prev_ack = sl_xferack;
    end
    check("held select ack count", 32'(acks), 32'd3);
    check("held select single-cycle acks", {31'd0, back_to_back}, 32'd0);
    bad_miss = 0;
    opb_abus   = 32'h01008400;
    opb_select = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (sl_xferack || sl_dbus != 32'd0) bad_miss = 1;
    end
    idle_inputs();
    check("miss no ack", {31'd0, bad_miss}, 32'd0);

    // Reset in the same cycle as a write: no ack, no write
    model_reset();
    @(posedge clk);
    #1;
    rst_n      = 1'b0;
    opb_abus   = BASE + 32'h8;
    opb_rnw    = 1'b0;
    opb_be     = 4'b0001;
    opb_dbus   = 32'h1;
    opb_select = 1'b1;
    @(posedge clk);
    #1;
    check("reset mid-transfer ack", {31'd0, sl_xferack}, 32'd0);
    check("reset mid-transfer frozen", {31'd0, user_frozen}, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    rd_chk("control after reset", BASE + 32'h8, 32'h00000000);

    // Count wrap after 65536 captures, capture against DATA-read clear
    do_reset();
    for (int i = 0; i < 65536; i++) begin
      user_data_valid = 1'b1;
      user_data_in    = 32'(i);
      @(posedge clk);
      #1;
      model_step(0, 0, 0, 4'h0, 32'd0, 1, 32'(i));
    end
    user_data_valid = 1'b0;
    rd_chk("count wrap status", BASE + 32'h4, 32'hC0000000);
    bus_op("read with strobe", BASE, 1'b1, 4'hF, 32'd0, 1'b1, 32'h0BADF00D, 1'b1, 32'h0000FFFF);
    rd_chk("fresh kept", BASE + 32'h4, 32'hC0000001);
    bus_op("w1c with strobe", BASE + 32'h4, 1'b0, 4'b1000, 32'hC0000000, 1'b1, 32'h0000BEEF,
           1'b1, 32'd0);
    rd_chk("capture beats w1c", BASE + 32'h4, 32'hC0000002);
    wr_op("w1c plain", BASE + 32'h4, 4'b1000, 32'hC0000000);
    rd_chk("flags cleared", BASE + 32'h4, 32'h00000002);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      int unsigned w;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] sd;
      logic [3:0]  b;
      bit          hit;
      bit          rd;
      bit          stb;
      kind = $urandom_range(0, 9);
      sd   = $urandom;
      if (kind < 3) begin
        strobe(sd);
      end else begin
        w   = $urandom_range(0, 3);
        hit = (kind != 9);
        if (hit) begin
          addr = BASE + 32'(w * 4) + 32'($urandom_range(0, 3));
        end else begin
          case ($urandom_range(0, 3))
            0:       addr = 32'h01008400;
            1:       addr = 32'h010082FC;
            2:       addr = 32'h00000000;
            default: addr = 32'hFFFFFFFC;
          endcase
        end
        rd  = $urandom_range(0, 1) == 1;
        stb = $urandom_range(0, 1) == 1;
        b   = 4'($urandom_range(0, 15));
        wd  = $urandom;
        bus_op($sformatf("rand%0d", n), addr, rd, b, wd, stb, sd, hit, model_read(w));
      end
    end
    rd_chk("final status", BASE + 32'h4, model_read(1));
    rd_chk("final data", BASE, model_read(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
